// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// No logic; imported by the arbiter top and its grant sub-module.
package dmem_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int PORT_CORE   = 0;
    localparam int PORT_HOST   = 1;
    localparam int DMEM_AW_DEF = 32;
    localparam int DMEM_DW_DEF = 32;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-request grant logic; DMEM_ARB_RR_EN selects round-robin, else port 0 wins ties.
// Latency: combinational grant; the last_grant register updates on contended handshakes.
// Backpressure: a loser simply sees no grant and retries while its request is held.
module rr_arb2
    import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic contended;

    assign contended = req[0] && req[1];

`ifdef DMEM_ARB_RR_EN
    logic last_grant;

    // Every granted request handshakes in the same cycle, so a contended cycle is a contended handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'(PORT_CORE);
        end else if (en && contended) begin
            last_grant <= ~last_grant;
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (contended) begin
                gnt = last_grant ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end
`else
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (contended) begin
                gnt = 2'b01;
            end else begin
                gnt = req;
            end
        end
    end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between core (port 0) and host (port 1); DMEM_ARB_RR_EN picks round-robin.
// Latency: request drives memory combinationally; response rvalid/rdata one cycle after handshake.
// Backpressure: at most one grant per cycle; the loser holds its request until ready.
module data_mem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = DMEM_AW_DEF,
    parameter int DW = DMEM_DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          m0_req_valid,
    output logic          m0_req_ready,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req_valid,
    output logic          m1_req_ready,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic          mem_rst,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    state_t        state, state_nxt;
    logic          run;
    logic [1:0]    gnt;
    logic          hs;
    logic          sel;
    logic          we_sel;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] din_sel;

    logic [AW-1:0] addr_hold;
    logic [DW-1:0] din_hold;
    logic          resp_valid;
    logic          resp_port;
    logic          resp_is_read;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    // FSM: outputs
    always_comb begin
        run     = 1'b0;
        mem_rst = 1'b1;
        case (state)
            ST_RUN: begin
                run     = 1'b1;
                mem_rst = !rst_n;
            end
            default: begin
                run     = 1'b0;
                mem_rst = 1'b1;
            end
        endcase
    end

    rr_arb2 u_arb (
`ifdef DMEM_ARB_RR_EN
        .clk   (clk),
        .rst_n (rst_n),
`endif
        .en    (run),
        .req   ({m1_req_valid, m0_req_valid}),
        .gnt   (gnt)
    );

    assign m0_req_ready = gnt[PORT_CORE];
    assign m1_req_ready = gnt[PORT_HOST];
    assign hs           = |gnt;
    assign sel          = gnt[PORT_HOST];

    always_comb begin
        we_sel   = m0_we;
        addr_sel = m0_addr;
        din_sel  = m0_wdata;
        if (sel) begin
            we_sel   = m1_we;
            addr_sel = m1_addr;
            din_sel  = m1_wdata;
        end
    end

    // Idle cycles replay the last granted address so the memory output stays put.
    assign mem_we   = hs && we_sel;
    assign mem_addr = hs ? addr_sel : addr_hold;
    assign mem_din  = hs ? din_sel  : din_hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_hold    <= '0;
            din_hold     <= '0;
            resp_valid   <= 1'b0;
            resp_port    <= 1'(PORT_CORE);
            resp_is_read <= 1'b0;
        end else begin
            resp_valid <= hs;
            if (hs) begin
                addr_hold    <= addr_sel;
                din_hold     <= din_sel;
                resp_port    <= sel;
                resp_is_read <= !we_sel;
            end
        end
    end

    assign m0_rvalid = resp_valid && (resp_port == 1'(PORT_CORE));
    assign m1_rvalid = resp_valid && (resp_port == 1'(PORT_HOST));
    assign m0_rdata  = (m0_rvalid && resp_is_read) ? mem_dout : '0;
    assign m1_rdata  = (m1_rvalid && resp_is_read) ? mem_dout : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural single-port memory.
// Expected values follow the round-robin or fixed-priority build via DMEM_ARB_RR_EN.
module tb_data_mem_arbiter;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req_valid, m0_req_ready, m0_we, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req_valid, m1_req_ready, m1_we, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_rst, mem_we;
    logic [31:0] mem_addr, mem_din, mem_dout;

    int n_vec = 0;
    int n_bad = 0;
    int cnt0, cnt1;

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    data_mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0_req_valid (m0_req_valid),
        .m0_req_ready (m0_req_ready),
        .m0_we        (m0_we),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_rvalid    (m0_rvalid),
        .m0_rdata     (m0_rdata),
        .m1_req_valid (m1_req_valid),
        .m1_req_ready (m1_req_ready),
        .m1_we        (m1_we),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_rvalid    (m1_rvalid),
        .m1_rdata     (m1_rdata),
        .mem_rst      (mem_rst),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout)
    );

    // Synchronous single-port memory: address captured at the edge, data out the next cycle.
    always @(posedge clk) begin
        if (mem_rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            mem_dout <= '0;
        end else begin
            if (mem_we) mem[mem_addr[7:2]] <= mem_din;
            mem_dout <= mem[mem_addr[7:2]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic p0(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        m0_req_valid = v; m0_we = we; m0_addr = a; m0_wdata = d;
    endtask

    task automatic p1(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        m1_req_valid = v; m1_we = we; m1_addr = a; m1_wdata = d;
    endtask

    initial begin
        rst_n = 1'b0;
        p0(1'b0, 1'b0, 32'h0, 32'h0);
        p1(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset held for three edges
        cyc(); cyc(); cyc();
        #3;
        chk("rst_mem_rst", 64'(mem_rst), 64'd1);
        chk("rst_ready0", 64'(m0_req_ready), 64'd0);
        chk("rst_ready1", 64'(m1_req_ready), 64'd0);
        chk("rst_rvalid", 64'({m1_rvalid, m0_rvalid}), 64'd0);
        chk("rst_rdata", {m1_rdata, m0_rdata}, 64'd0);
        chk("rst_mem_bus", {31'd0, mem_we, mem_addr}, 64'd0);
        chk("rst_mem_din", 64'(mem_din), 64'd0);

        // INIT cycle: rst_n released, port-0 read waits
        rst_n = 1'b1;
        p0(1'b1, 1'b0, 32'h10, 32'h0);
        #3;
        chk("init_mem_rst", 64'(mem_rst), 64'd1);
        chk("init_ready0", 64'(m0_req_ready), 64'd0);
        chk("init_mem_we", 64'(mem_we), 64'd0);
        cyc();

        // First RUN cycle: read 0x10 accepted
        #3;
        chk("run_mem_rst", 64'(mem_rst), 64'd0);
        chk("run_ready0", 64'(m0_req_ready), 64'd1);
        chk("run_mem_addr", 64'(mem_addr), 64'h10);
        cyc();

        // Write 0xDEADBEEF to 0x04
        p0(1'b1, 1'b1, 32'h04, 32'hDEADBEEF);
        #3;
        chk("wr_ready0", 64'(m0_req_ready), 64'd1);
        chk("wr_mem_we", 64'(mem_we), 64'd1);
        chk("wr_mem_din", 64'(mem_din), 64'hDEADBEEF);
        chk("rd10_rvalid", 64'(m0_rvalid), 64'd1);
        chk("rd10_rdata", 64'(m0_rdata), 64'd0);
        cyc();

        // Read 0x04 back-to-back
        p0(1'b1, 1'b0, 32'h04, 32'h0);
        #3;
        chk("wr_resp_rvalid", 64'(m0_rvalid), 64'd1);
        chk("wr_resp_rdata", 64'(m0_rdata), 64'd0);
        cyc();

        p0(1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        chk("rd04_rvalid", 64'(m0_rvalid), 64'd1);
        chk("rd04_rdata", 64'(m0_rdata), 64'hDEADBEEF);
        chk("idle_mem_we", 64'(mem_we), 64'd0);
        chk("idle_addr_hold", 64'(mem_addr), 64'h04);
        cyc();
        #3;
        chk("idle_rvalid0", 64'(m0_rvalid), 64'd0);
        cyc();

        // Contention: both read 0x08 for four cycles
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 5; i++) begin
            p0(i < 4, 1'b0, 32'h08, 32'h0);
            p1(i < 4, 1'b0, 32'h08, 32'h0);
            #3;
            if (i < 4) begin
                chk($sformatf("cont_ready0_%0d", i), 64'(m0_req_ready), 64'(!(RR && (i % 2 == 0))));
                chk($sformatf("cont_ready1_%0d", i), 64'(m1_req_ready), 64'(RR && (i % 2 == 0)));
            end
            cnt0 += int'(m0_rvalid);
            cnt1 += int'(m1_rvalid);
            cyc();
        end
        chk("cont_pulses0", 64'(cnt0), RR ? 64'd2 : 64'd4);
        chk("cont_pulses1", 64'(cnt1), RR ? 64'd2 : 64'd0);

        // Cross-port: port 1 writes, port 0 reads
        p1(1'b1, 1'b1, 32'h20, 32'h12345678);
        #3;
        chk("xw_ready1", 64'(m1_req_ready), 64'd1);
        chk("xw_mem_we", 64'(mem_we), 64'd1);
        cyc();
        p1(1'b0, 1'b0, 32'h0, 32'h0);
        p0(1'b1, 1'b0, 32'h20, 32'h0);
        #3;
        chk("xw_resp1", {31'd0, m1_rvalid, m1_rdata}, {31'd0, 1'b1, 32'h0});
        chk("xw_rvalid0", 64'(m0_rvalid), 64'd0);
        cyc();
        p0(1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        chk("xr_rvalid0", 64'(m0_rvalid), 64'd1);
        chk("xr_rdata0", 64'(m0_rdata), 64'h12345678);
        chk("xr_rvalid1", 64'(m1_rvalid), 64'd0);
        cyc();

        // One contended read to set a known priority state in both builds
        p0(1'b1, 1'b0, 32'h08, 32'h0);
        p1(1'b1, 1'b0, 32'h08, 32'h0);
        #3;
        chk("pre_ready1", 64'(m1_req_ready), 64'(RR));
        cyc();

        // Withdrawn request: port 1 loses once then drops valid
        p0(1'b1, 1'b0, 32'h0C, 32'h0);
        p1(1'b1, 1'b1, 32'h30, 32'hAAAA5555);
        #3;
        chk("wd_ready0", 64'(m0_req_ready), 64'd1);
        chk("wd_ready1", 64'(m1_req_ready), 64'd0);
        chk("wd_mem_we", 64'(mem_we), 64'd0);
        chk("pre_rvalid", 64'({m1_rvalid, m0_rvalid}), RR ? 64'd2 : 64'd1);
        cyc();
        p0(1'b0, 1'b0, 32'h0, 32'h0);
        p1(1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        chk("wd_rvalid1", 64'(m1_rvalid), 64'd0);
        chk("wd_rvalid0", 64'(m0_rvalid), 64'd1);
        cyc();
        p0(1'b1, 1'b0, 32'h30, 32'h0);
        #3;
        chk("wd_rd_ready0", 64'(m0_req_ready), 64'd1);
        cyc();
        p0(1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        chk("wd_rd30", {31'd0, m0_rvalid, m0_rdata}, {31'd0, 1'b1, 32'h0});
        cyc();

        // Reset mid-operation: port-1 read accepted as reset is sampled
        p1(1'b1, 1'b0, 32'h04, 32'h0);
        rst_n = 1'b0;
        #3;
        chk("mid_ready1", 64'(m1_req_ready), 64'd1);
        chk("mid_mem_rst", 64'(mem_rst), 64'd1);
        cyc();
        p1(1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        #3;
        chk("mid_rvalid1", 64'(m1_rvalid), 64'd0);
        chk("mid_init_rst", 64'(mem_rst), 64'd1);
        chk("mid_init_ready", 64'({m1_req_ready, m0_req_ready}), 64'd0);
        chk("mid_addr_clr", 64'(mem_addr), 64'd0);
        cyc();
        p0(1'b1, 1'b0, 32'h04, 32'h0);
        #3;
        chk("post_ready0", 64'(m0_req_ready), 64'd1);
        cyc();
        p0(1'b0, 1'b0, 32'h0, 32'h0);
        p1(1'b1, 1'b0, 32'h20, 32'h0);
        #3;
        chk("post_rd04", {31'd0, m0_rvalid, m0_rdata}, {31'd0, 1'b1, 32'h0});
        chk("post_ready1", 64'(m1_req_ready), 64'd1);
        cyc();
        p1(1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        chk("post_rd20", {31'd0, m1_rvalid, m1_rdata}, {31'd0, 1'b1, 32'h0});
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single-port data memory between the core load/store unit (port 0) and the host-side loader/debug port (port 1). It grants at most one request per cycle to the memory, drives the memory's request inputs combinationally, and returns each read response to its issuer one cycle later. It also owns the memory's clear sequence after reset.

## Interface
Parameters:
- `AW`, default 32: request address width, passed unchanged to the memory.
- `DW`, default 32: data width.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `m0_req_valid` / `m1_req_valid`  in  1 each  request valid.
- `m0_req_ready` / `m1_req_ready`  out  1 each  request accepted this cycle.
- `m0_we` / `m1_we`  in  1 each  1 = write, 0 = read.
- `m0_addr` / `m1_addr`  in  AW each  byte address.
- `m0_wdata` / `m1_wdata`  in  DW each  write data.
- `m0_rvalid` / `m1_rvalid`  out  1 each  response pulse for an accepted request.
- `m0_rdata` / `m1_rdata`  out  DW each  read data; 0 for write responses.
- `mem_rst`  out  1  active-high clear to the memory.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  AW  memory address.
- `mem_din`  out  DW  memory write data.
- `mem_dout`  in  DW  memory read data. The memory registers its address on the same edge as the request, so read data is valid in the following cycle.

## Operation
- The FSM has two states, INIT and RUN.
- While `rst_n`=0, the next state is INIT. INIT lasts exactly one cycle after `rst_n` rises, then the FSM moves to RUN and stays there.
- `mem_rst` = 1 while `rst_n`=0 and during INIT. It is 0 in RUN.
- In INIT, both `req_ready` outputs are 0 and `mem_we`=0.
- In RUN, grant logic is combinational from the valids and the priority state:
  - Only one valid: that port is granted.
  - Both valid: the port chosen by the priority policy (see Configuration) is granted.
  - The granted port's `req_ready` = 1. A handshake is `valid && ready` in the same cycle.
- Memory drive:
  - With a grant: `mem_addr`/`mem_din`/`mem_we` mirror the granted port.
  - With no grant: `mem_we`=0. `mem_addr` and `mem_din` hold the last granted values, so the memory output stays stable.
- Response tracking uses registered `resp_valid`, `resp_port` and `resp_is_read`, loaded on every handshake.
  - Next cycle, `m<resp_port>_rvalid`=1.
  - Its `rdata` = `mem_dout` for a read and 0 for a write.
  - The other port's `rvalid` = 0 and its `rdata` = 0.
- Requesters need not wait for a response before issuing again. Back-to-back handshakes every cycle are legal.
- No read-after-write hazard exists: the memory commits a write one edge after capture, and a following read's data is sampled one cycle later still. The arbiter never stalls for ordering.
- Request fields must be held stable while valid=1 and ready=0. A valid deasserted before handshake is a dropped request, not an error.

## Timing
- Reset values: `mem_rst`=1, every `req_ready`=0, every `rvalid`=0, every `rdata`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0. The priority state points to port 0 and the response registers are cleared.
- First handshake is possible at the second cycle after `rst_n` rises, i.e. the first RUN cycle.
- Latency: handshake in cycle t gives `rvalid` in t+1. Throughput is one access per cycle, total across both ports.
- Reset asserted mid-operation: on the next edge, the pending response is discarded (no `rvalid`), the priority state resets, and the memory is cleared.
- A held losing request is granted within at most one cycle of contention when the priority feature is compiled in.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. A 1-bit `last_grant` register is updated only on contended handshakes. On contention, the port other than `last_grant` wins.
- Not defined: fixed priority, port 0 always wins on contention. The `last_grant` register is not built.

## Structure
- Package `dmem_arb_pkg` holds:
  - the FSM state typedef (INIT, RUN);
  - the port index constants `PORT_CORE`=0 and `PORT_HOST`=1;
  - the `AW`/`DW` defaults.
- One sub-module, `rr_arb2`: two-request grant logic with the optional `last_grant` register. The top level holds the FSM, the memory mux and the response registers.

## Test plan
- Reset release: hold `rst_n`=0 for 3 cycles, then raise it → `mem_rst`=1 until the end of the INIT cycle. Both readies are 0 in INIT, and a port-0 read of 0x10 is accepted on the first RUN cycle.
- Write then read, port 0: write 0xDEADBEEF to 0x04, then read 0x04 the next cycle → `m0_rvalid` on both following cycles, second `m0_rdata`=0xDEADBEEF, first `m0_rdata`=0.
- Contention, RR build: both ports read 0x08 continuously for 4 cycles → grants go 1,0,1,0 and each port sees two `rvalid` pulses. In the fixed-priority build, port 1 never gets ready.
- Cross-port: port 1 writes 0x12345678 to 0x20, port 0 reads 0x20 the next cycle → `m0_rdata`=0x12345678.
- Reset mid-operation: port 1 read is accepted, `rst_n`=0 on the next edge → no `m1_rvalid`, and a later read of any previously written address returns 0.
- Withdrawn request: port 1 is valid for one contended cycle with no ready, then drops valid → no `m1_rvalid` and no memory write.
